twiddle_gen: RTL and testbench

TWIDDLE_GEN -- requirements
Module: twiddle_gen

---
 rtl/twiddle_gen.sv | 146 ++++++++++++++
 tb/tb_twiddle_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_gen.sv
// twiddle_gen: per-stage FFT twiddle sequencer.
// For each accepted sample it reports the stage phase (FILL/BFLY/TWID), the
// twiddle exponent k, and the Q(FRAC) twiddle e^-j2pi k/N (or its conjugate
// when inverse=1). Twiddles come from a half-period table built at elaboration.
// Build option: define TWIDDLE_OUT_REG_EN to register all outputs (one cycle
// latency); left undefined, outputs are combinational from the counters.
module twiddle_gen #(
    parameter int unsigned STAGE_N = 8,
    parameter int unsigned WIDTH   = 24,
    parameter int unsigned FRAC    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic                         clr,
    input  logic                         inverse,
    output logic [WIDTH-1:0]             w_r,
    output logic [WIDTH-1:0]             w_i,
    output logic [1:0]                   state,
    output logic [$clog2(STAGE_N)-2:0]   tw_idx,
    output logic                         out_valid
);

    localparam int unsigned HALF  = STAGE_N / 2;
    localparam int unsigned PH_W  = $clog2(STAGE_N);
    localparam int unsigned IDX_W = PH_W - 1;
    localparam int unsigned FC_W  = $clog2(HALF) + 1;
    localparam real         PI    = 3.14159265358979323846;

    // Unity in Q(FRAC); WIDTH >= FRAC+2 guarantees a zero sign bit above it.
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    localparam logic [1:0] ST_FILL = 2'd0;
    localparam logic [1:0] ST_BFLY = 2'd1;
    localparam logic [1:0] ST_TWID = 2'd2;

    // Round-half-away-from-zero of cos/sin(2*pi*k/N) scaled to Q(FRAC).
    function automatic int trig_q(input int k, input bit use_sin);
        real ang;
        real v;
        ang = 2.0 * PI * real'(k) / real'(STAGE_N);
        v   = (use_sin ? $sin(ang) : $cos(ang)) * real'(1 << FRAC);
        if (v >= 0.0) return $rtoi($floor(v + 0.5));
        else          return -$rtoi($floor(-v + 0.5));
    endfunction

    logic [WIDTH-1:0] cos_tab [HALF];
    logic [WIDTH-1:0] sin_tab [HALF];

    // Constant twiddle table for k = 0 .. N/2-1 (sin stored with positive sign).
    for (genvar g = 0; g < HALF; g++) begin : g_tab
        assign cos_tab[g] = WIDTH'(trig_q(g, 1'b0));
        assign sin_tab[g] = WIDTH'(trig_q(g, 1'b1));
    end

    logic [FC_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic [IDX_W-1:0] k;

    assign k = ph_q[IDX_W-1:0];

    // Sequence advance: fill first, then phase walks modulo N; clr has priority.
    always_comb begin
        fill_cnt_d = fill_cnt_q;
        ph_d       = ph_q;
        if (clr) begin
            fill_cnt_d = '0;
            ph_d       = '0;
        end else if (in_valid) begin
            if (fill_cnt_q < FC_W'(HALF)) fill_cnt_d = fill_cnt_q + FC_W'(1);
            else                          ph_d       = ph_q + PH_W'(1);
        end
    end

    // Sequence state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_q <= '0;
            ph_q       <= '0;
        end else begin
            fill_cnt_q <= fill_cnt_d;
            ph_q       <= ph_d;
        end
    end

    logic [WIDTH-1:0] w_r_d, w_i_d;
    logic [1:0]       state_d;
    logic [IDX_W-1:0] tw_idx_d;
    logic             out_valid_d;

    // Phase decode and twiddle lookup, from the counter registers only.
    always_comb begin
        state_d  = ST_FILL;
        tw_idx_d = '0;
        w_r_d    = ONE;
        w_i_d    = '0;
        if (fill_cnt_q >= FC_W'(HALF)) begin
            if (ph_q < PH_W'(HALF)) begin
                state_d = ST_BFLY;
            end else begin
                state_d  = ST_TWID;
                tw_idx_d = k;
                w_r_d    = cos_tab[k];
                w_i_d    = inverse ? sin_tab[k] : (WIDTH'(0) - sin_tab[k]);
            end
        end
        out_valid_d = in_valid && (state_d != ST_FILL);
    end

`ifdef TWIDDLE_OUT_REG_EN
    logic [WIDTH-1:0] w_r_q, w_i_q;
    logic [1:0]       state_q;
    logic [IDX_W-1:0] tw_idx_q;
    logic             out_valid_q;

    // Output stage: one cycle behind the sample it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_r_q       <= ONE;
            w_i_q       <= '0;
            state_q     <= ST_FILL;
            tw_idx_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            w_r_q       <= w_r_d;
            w_i_q       <= w_i_d;
            state_q     <= state_d;
            tw_idx_q    <= tw_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign w_r       = w_r_q;
    assign w_i       = w_i_q;
    assign state     = state_q;
    assign tw_idx    = tw_idx_q;
    assign out_valid = out_valid_q;
`else
    assign w_r       = w_r_d;
    assign w_i       = w_i_d;
    assign state     = state_d;
    assign tw_idx    = tw_idx_d;
    assign out_valid = out_valid_d;
`endif

endmodule

// File: tb/tb_twiddle_gen.sv
// tb_twiddle_gen: self-checking bench for twiddle_gen (N=8 instance plus an
// N=1024/FRAC=14 instance). Expected values come from hand tables and from a
// sample-count model that evaluates the twiddle formula directly.
module tb_twiddle_gen;

    localparam int N   = 8;
    localparam int FR  = 8;
    localparam int W   = 24;
    localparam int NB  = 1024;
    localparam int FRB = 14;
`ifdef TWIDDLE_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        int st;
        int idx;
        int wr;
        int wi;
        bit ov;
    } exp_t;

    typedef struct {
        bit   iv;
        bit   inv;
        exp_t e;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid, clr, inverse;
    logic [W-1:0]  w_r, w_i;
    logic [1:0]    state;
    logic [1:0]    tw_idx;
    logic          out_valid;

    logic          in_valid_b, clr_b, inverse_b;
    logic [W-1:0]  w_r_b, w_i_b;
    logic [1:0]    state_b;
    logic [8:0]    tw_idx_b;
    logic          out_valid_b;

    twiddle_gen #(.STAGE_N(N), .WIDTH(W), .FRAC(FR)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .clr(clr), .inverse(inverse),
        .w_r(w_r), .w_i(w_i), .state(state), .tw_idx(tw_idx), .out_valid(out_valid)
    );

    twiddle_gen #(.STAGE_N(NB), .WIDTH(W), .FRAC(FRB)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .clr(clr_b), .inverse(inverse_b),
        .w_r(w_r_b), .w_i(w_i_b), .state(state_b), .tw_idx(tw_idx_b), .out_valid(out_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_pass = 0;
    int    n_tot  = 0;
    int    cnt    = 0;
    exp_t  pend;
    string pend_tag;
    bit    have_pend = 0;

    function automatic int rnd_haz(input real x);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        else          return -$rtoi($floor(-x + 0.5));
    endfunction

    // Reference: expected outputs for the sample numbered cnt since restart.
    function automatic exp_t model(input int c, input int n, input int frac,
                                   input bit inv, input bit iv);
        exp_t e;
        int   half, p, kk;
        real  ang, sc;
        half  = n / 2;
        e.st  = 0;
        e.idx = 0;
        e.wr  = 1 << frac;
        e.wi  = 0;
        if (c >= half) begin
            p = (c - half) % n;
            if (p < half) begin
                e.st = 1;
            end else begin
                kk    = p - half;
                e.st  = 2;
                e.idx = kk;
                ang   = 2.0 * 3.14159265358979323846 * real'(kk) / real'(n);
                sc    = real'(1 << frac);
                e.wr  = rnd_haz($cos(ang) * sc);
                e.wi  = inv ? rnd_haz($sin(ang) * sc) : -rnd_haz($sin(ang) * sc);
            end
        end
        e.ov = iv && (e.st != 0);
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cmp_dut(input string tag, input exp_t e);
        int a_wr, a_wi, a_st, a_idx;
        a_wr  = $signed(w_r);
        a_wi  = $signed(w_i);
        a_st  = state;
        a_idx = tw_idx;
        check({tag, ".state"}, a_st, e.st);
        check({tag, ".tw_idx"}, a_idx, e.idx);
        check({tag, ".w_r"}, a_wr, e.wr);
        check({tag, ".w_i"}, a_wi, e.wi);
        check({tag, ".out_valid"}, int'(out_valid), int'(e.ov));
    endtask

    // One input cycle; compares now (combinational) or on the next cycle (registered).
    task automatic step(input bit iv, input bit c, input bit inv,
                        input bit use_tab, input exp_t tab, input string tag);
        exp_t e;
        @(negedge clk);
        in_valid = iv;
        clr      = c;
        inverse  = inv;
        #1;
        e = use_tab ? tab : model(cnt, N, FR, inv, iv);
        if (LAT == 0) begin
            cmp_dut(tag, e);
        end else begin
            if (have_pend) cmp_dut(pend_tag, pend);
            pend      = e;
            pend_tag  = tag;
            have_pend = 1;
        end
        if (c) cnt = 0;
        else if (iv) cnt++;
    endtask

    task automatic chk_reset_vals(input string tag);
        exp_t e;
        e.st = 0; e.idx = 0; e.wr = 1 << FR; e.wi = 0; e.ov = 0;
        cmp_dut(tag, e);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        clr       = 1'b0;
        cnt       = 0;
        have_pend = 0;
    endtask

    exp_t nul;
    exp_t ex;
    vec_t tab [13];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; inverse = 1'b0;
        in_valid_b = 1'b0; clr_b = 1'b0; inverse_b = 1'b0;
        nul = '{0, 0, 0, 0, 1'b0};

        for (int i = 0; i < 13; i++) tab[i].iv = 1'b1;
        for (int i = 0; i < 13; i++) tab[i].inv = 1'b0;
        for (int i = 0; i < 4; i++)  tab[i].e = '{0, 0, 256, 0, 1'b0};
        for (int i = 4; i < 8; i++)  tab[i].e = '{1, 0, 256, 0, 1'b1};
        tab[8].e  = '{2, 0, 256, 0, 1'b1};
        tab[9].e  = '{2, 1, 181, -181, 1'b1};
        tab[10].e = '{2, 2, 0, -256, 1'b1};
        tab[11].e = '{2, 3, -181, -181, 1'b1};
        tab[12].e = '{1, 0, 256, 0, 1'b1};

        #2;
        chk_reset_vals("por");
        repeat (2) @(negedge clk);
        release_reset();

        // Fill, butterfly, twiddle k=0..3, then wrap to butterfly.
        for (int i = 0; i < 13; i++)
            step(tab[i].iv, 1'b0, tab[i].inv, 1'b1, tab[i].e, $sformatf("seq%0d", i));

        // Restart, run to k=1 with inverse, stall at k=2, resume to k=3.
        step(1'b1, 1'b1, 1'b0, 1'b0, nul, "clr0");
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, 1'b0, nul, $sformatf("pre%0d", i));
        ex = '{2, 1, 181, 181, 1'b1};
        step(1'b1, 1'b0, 1'b1, 1'b1, ex, "inv_k1");
        ex = '{2, 2, 0, -256, 1'b0};
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, ex, $sformatf("stall%0d", i));
        ex = '{2, 2, 0, -256, 1'b1};
        step(1'b1, 1'b0, 1'b0, 1'b1, ex, "resume_k2");
        ex = '{2, 3, -181, -181, 1'b1};
        step(1'b1, 1'b0, 1'b0, 1'b1, ex, "resume_k3");

        // clr together with in_valid during TWID.
        while (cnt != 17) step(1'b1, 1'b0, 1'b0, 1'b0, nul, "walk");
        step(1'b1, 1'b1, 1'b0, 1'b0, nul, "clr_twid");
        ex = '{0, 0, 256, 0, 1'b0};
        step(1'b1, 1'b0, 1'b0, 1'b1, ex, "after_clr");

        // Asynchronous reset mid-butterfly.
        while (cnt != 6) step(1'b1, 1'b0, 1'b0, 1'b0, nul, "walk2");
        @(negedge clk);
        in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_bfly");
        release_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, nul, "post_rst0");
        step(1'b1, 1'b0, 1'b0, 1'b0, nul, "post_rst1");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)), 1'b0, nul, $sformatf("rnd%0d", i));
        step(1'b0, 1'b0, 1'b0, 1'b0, nul, "flush");

        // Large stage: k=1 (model) and k=256 (fixed values).
        @(negedge clk);
        clr_b = 1'b1;
        @(negedge clk);
        clr_b = 1'b0;
        for (int s = 0; s <= NB + NB / 2 + 257; s++) begin
            @(negedge clk);
            in_valid_b = (s <= NB + NB / 2 + 256);
            #1;
            if (s - LAT == NB / 2 + NB / 2 + 1) begin
                ex = model(s - LAT, NB, FRB, 1'b0, 1'b1);
                check("big_k1.state", int'(state_b), ex.st);
                check("big_k1.tw_idx", int'(tw_idx_b), ex.idx);
                check("big_k1.w_r", $signed(w_r_b), ex.wr);
                check("big_k1.w_i", $signed(w_i_b), ex.wi);
            end
            if (s - LAT == NB + NB / 2 - 256) begin
                check("big_k256.state", int'(state_b), 2);
                check("big_k256.tw_idx", int'(tw_idx_b), 256);
                check("big_k256.w_r", $signed(w_r_b), 0);
                check("big_k256.w_i", $signed(w_i_b), -16384);
                check("big_k256.out_valid", int'(out_valid_b), 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
